// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the three-digit seven-segment scan controller.
// Holds FSM/digit encodings, segment constants and the double-dabble step.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  function automatic logic [2:0] digit_enable(input digit_t d);
    logic [2:0] en;
    en = 3'b111;
    case (d)
      DIG_UNITS:    en = 3'b110;
      DIG_TENS:     en = 3'b101;
      DIG_HUNDREDS: en = 3'b011;
      default:      en = 3'b111;
    endcase
    return en;
  endfunction

  // One double-dabble iteration: correct each BCD nibble, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_led7seg.sv
// BCD digit to seven-segment decoder, {g..a} active-low.
// Codes above 9 produce a dark digit.
module led7seg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Binary-to-BCD converter feeding a multiplexed three-digit display with
// leading-zero blanking and overflow blink.
//
// state | meaning
// IDLE  | ready for a new value
// CONV  | eight double-dabble shifts in progress
// LATCH | copy BCD result into the display registers
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] val_i,
  input  logic       val_valid_i,
  output logic       val_ready_o,
  input  logic       of_i,
  output logic [6:0] seg_o,
  output logic [2:0] an_o,
  output logic       busy_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t      state, state_nxt;
  logic [19:0] sr, sr_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        latch;

  logic [3:0]  hund, tens, units;
  logic [3:0]  hund_nxt, tens_nxt, units_nxt;

  logic [PW-1:0] presc, presc_nxt;
  logic          tick;
  digit_t        idx, idx_nxt;

  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          phase_off, phase_off_nxt;

  logic [3:0]  sel_digit;
  logic        sel_blank;
  logic [6:0]  dec_seg;
  logic [6:0]  seg_nxt;
  logic [6:0]  seg_q;
  logic [2:0]  an_q;

  // Conversion FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sr      <= 20'd0;
      bit_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    latch       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (val_valid_i) begin
          sr_nxt      = {12'd0, val_i};
          bit_cnt_nxt = 3'd0;
          state_nxt   = ST_CONV;
        end
      end
      ST_CONV: begin
        sr_nxt      = dabble_step(sr);
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        latch     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign val_ready_o = (state == ST_IDLE);
  assign busy_o      = ~val_ready_o;

  assign hund_nxt  = latch ? sr[19:16] : hund;
  assign tens_nxt  = latch ? sr[15:12] : tens;
  assign units_nxt = latch ? sr[11:8]  : units;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hund  <= 4'd0;
      tens  <= 4'd0;
      units <= 4'd0;
    end else begin
      hund  <= hund_nxt;
      tens  <= tens_nxt;
      units <= units_nxt;
    end
  end

  // Scan prescaler and digit rotation
  assign tick      = (presc == PW'(SCAN_DIV - 1));
  assign presc_nxt = tick ? '0 : presc + PW'(1);

  always_comb begin
    idx_nxt = idx;
    if (tick) begin
      case (idx)
        DIG_UNITS:    idx_nxt = DIG_TENS;
        DIG_TENS:     idx_nxt = DIG_HUNDREDS;
        DIG_HUNDREDS: idx_nxt = DIG_UNITS;
        default:      idx_nxt = DIG_UNITS;
      endcase
    end
  end

  always_comb begin
    blink_cnt_nxt = blink_cnt;
    phase_off_nxt = phase_off;
    if (!of_i) begin
      blink_cnt_nxt = '0;
      phase_off_nxt = 1'b0;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt_nxt = '0;
        phase_off_nxt = ~phase_off;
      end else begin
        blink_cnt_nxt = blink_cnt + BW'(1);
      end
    end
  end

  // Output pattern is built from next-state values so an_o and seg_o switch together.
  always_comb begin
    sel_digit = units_nxt;
    sel_blank = 1'b0;
    case (idx_nxt)
      DIG_HUNDREDS: begin
        sel_digit = hund_nxt;
        sel_blank = (hund_nxt == 4'd0);
      end
      DIG_TENS: begin
        sel_digit = tens_nxt;
        sel_blank = (hund_nxt == 4'd0) && (tens_nxt == 4'd0);
      end
      default: begin
        sel_digit = units_nxt;
        sel_blank = 1'b0;
      end
    endcase
  end

  led7seg u_led7seg (
    .digit (sel_digit),
    .seg   (dec_seg)
  );

  assign seg_nxt = (sel_blank || (of_i && phase_off_nxt)) ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      idx       <= DIG_UNITS;
      blink_cnt <= '0;
      phase_off <= 1'b0;
      an_q      <= 3'b110;
      seg_q     <= SEG_ZERO;
    end else begin
      presc     <= presc_nxt;
      idx       <= idx_nxt;
      blink_cnt <= blink_cnt_nxt;
      phase_off <= phase_off_nxt;
      an_q      <= digit_enable(idx_nxt);
      seg_q     <= seg_nxt;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a decimal/time-based reference model
// checked every cycle, plus directed literal checks and random traffic.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] val_i;
  logic       val_valid_i;
  logic       val_ready_o;
  logic       of_i;
  logic [6:0] seg_o;
  logic [2:0] an_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .val_i       (val_i),
    .val_valid_i (val_valid_i),
    .val_ready_o (val_ready_o),
    .of_i        (of_i),
    .seg_o       (seg_o),
    .an_o        (an_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: edges since reset, countdown to latch, decimal digits.
  int m_edges, m_busy, m_pend, m_h, m_t, m_u, m_ticks;
  bit m_of;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0; m_busy = 0; m_pend = 0;
      m_h = 0; m_t = 0; m_u = 0; m_ticks = 0; m_of = 0;
    end else begin
      m_edges++;
      if (m_busy == 0) begin
        if (val_valid_i) begin
          m_pend = val_i;
          m_busy = 9;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_h = m_pend / 100;
          m_t = (m_pend / 10) % 10;
          m_u = m_pend % 10;
        end
      end
      m_of = of_i;
      if (!of_i) m_ticks = 0;
      else if (m_edges % SCAN_DIV == 0) m_ticks++;
    end
  end

  function automatic logic [6:0] font(input int d);
    logic [6:0] tbl [0:9];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic logic [2:0] exp_an();
    int i;
    i = (m_edges / SCAN_DIV) % 3;
    return (i == 0) ? 3'b110 : (i == 1) ? 3'b101 : 3'b011;
  endfunction

  function automatic logic [6:0] exp_seg();
    int i;
    i = (m_edges / SCAN_DIV) % 3;
    if (m_of && ((m_ticks / BLINK_DIV) % 2 == 1)) return 7'h7F;
    if (i == 2) return (m_h == 0) ? 7'h7F : font(m_h);
    if (i == 1) return (m_h == 0 && m_t == 0) ? 7'h7F : font(m_t);
    return font(m_u);
  endfunction

  always @(negedge clk) begin
    checks++;
    if (val_ready_o !== (m_busy == 0)) begin
      errors++;
      $display("FAIL ready t=%0t got %b want %b", $time, val_ready_o, (m_busy == 0));
    end
    checks++;
    if (busy_o !== (m_busy != 0)) begin
      errors++;
      $display("FAIL busy t=%0t got %b want %b", $time, busy_o, (m_busy != 0));
    end
    checks++;
    if (an_o !== exp_an()) begin
      errors++;
      $display("FAIL an t=%0t got %b want %b", $time, an_o, exp_an());
    end
    checks++;
    if (seg_o !== exp_seg()) begin
      errors++;
      $display("FAIL seg t=%0t got %h want %h", $time, seg_o, exp_seg());
    end
  end

  task automatic lit(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] v);
    int guard;
    guard = 0;
    val_i = v;
    val_valid_i = 1'b1;
    @(negedge clk);
    while (!val_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) lit("send_timeout", guard, 0);
    @(posedge clk);
    #2;
    val_valid_i = 1'b0;
  endtask

  task automatic wait_an(input logic [2:0] a);
    int guard;
    guard = 0;
    @(negedge clk);
    while (an_o !== a && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) lit("an_timeout", guard, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    lit("rst_an", an_o, 3'b110);
    lit("rst_seg", seg_o, 7'h40);
    lit("rst_ready", val_ready_o, 1);
    lit("rst_busy", busy_o, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt, acc_prev, acc_n, cyc;
    rst_n = 1'b0;
    val_i = 8'd0;
    val_valid_i = 1'b0;
    of_i = 1'b0;
    #12;
    do_reset();

    // 255: digits 2/5/5
    send(8'd255);
    step(10);
    wait_an(3'b011); lit("h255", seg_o, 7'h24);
    wait_an(3'b110); lit("u255", seg_o, 7'h12);
    wait_an(3'b101); lit("t255", seg_o, 7'h12);

    // blink: 8 dark cycles with BLINK_DIV=2, SCAN_DIV=4
    of_i = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (seg_o !== 7'h7F && cnt < 40) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (seg_o === 7'h7F && cnt < 40) begin @(negedge clk); cnt++; end
    lit("blink_off_len", cnt, 8);
    step(13);
    of_i = 1'b0;
    step(3);

    // 7: leading zeros blanked
    send(8'd7);
    step(10);
    wait_an(3'b011); lit("h7", seg_o, 7'h7F);
    wait_an(3'b101); lit("t7", seg_o, 7'h7F);
    wait_an(3'b110); lit("u7", seg_o, 7'h78);

    // 100: interior zeros shown
    send(8'd100);
    step(10);
    wait_an(3'b101); lit("t100", seg_o, 7'h40);
    wait_an(3'b011); lit("h100", seg_o, 7'h79);

    // 42 with 99 offered during conversion
    send(8'd42);
    val_i = 8'd99;
    val_valid_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!val_ready_o) cnt++;
      @(posedge clk); #2;
    end
    val_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!val_ready_o) cnt++;
    end
    lit("busy_len", cnt, 9);
    wait_an(3'b101); lit("t42", seg_o, 7'h19);
    wait_an(3'b110); lit("u42", seg_o, 7'h24);

    // reset in the 4th conversion cycle of 200
    send(8'd200);
    step(3);
    do_reset();
    send(8'd13);
    step(10);
    wait_an(3'b101); lit("t13", seg_o, 7'h79);
    wait_an(3'b110); lit("u13", seg_o, 7'h30);
    wait_an(3'b011); lit("h13", seg_o, 7'h7F);

    // back-to-back 0,1,2 with valid held
    val_i = 8'd0;
    val_valid_i = 1'b1;
    acc_n = 0; acc_prev = 0; cyc = 0;
    while (acc_n < 3 && cyc < 60) begin
      @(negedge clk);
      if (val_ready_o) begin
        if (acc_n > 0) lit("b2b_gap", cyc - acc_prev, 10);
        acc_prev = cyc;
        acc_n++;
        @(posedge clk); #2;
        val_i = 8'(acc_n);
      end else begin
        @(posedge clk); #2;
      end
      cyc++;
    end
    val_valid_i = 1'b0;
    lit("b2b_count", acc_n, 3);
    step(11);
    wait_an(3'b110); lit("u2", seg_o, 7'h24);
    wait_an(3'b101); lit("t2", seg_o, 7'h7F);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      val_i = 8'($urandom_range(0, 255));
      val_valid_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) of_i = ~of_i;
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step($urandom_range(1, 3));
    end
    rst_n = 1'b1;
    val_valid_i = 1'b0;
    of_i = 1'b0;
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles each digit is driven (min 2).
REQ-002 SHALL have parameter BLINK_DIV, default 256, scan ticks per overflow-blink half-period (min 1).
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 val_i  in  8  binary count value to display.
REQ-006 val_valid_i  in  1  val_i offered this cycle.
REQ-007 val_ready_o  out  1  block accepts val_i this cycle.
REQ-008 of_i  in  1  overflow flag from the counter; level-sensitive.
REQ-009 seg_o  out  7  segment pattern {g..a}, active-low.
REQ-010 an_o  out  3  digit enables, active-low one-hot; [2]=hundreds, [1]=tens, [0]=units.
REQ-011 busy_o  out  1  conversion in progress (= !val_ready_o).

Function
REQ-012 FSM states: IDLE, CONV, LATCH; val_ready_o=1 only in IDLE.
REQ-013 Handshake: transfer when val_valid_i && val_ready_o; val_valid_i outside IDLE ignored, no queuing.
REQ-014 On transfer edge: 20-bit shift register = {12'd0, val_i}, bit counter = 0, IDLE->CONV.
REQ-015 CONV, each cycle: every BCD nibble >=5 gets +3, then whole register shifts left 1; after the 8th shift -> LATCH.
REQ-016 LATCH: hundreds/tens/units display registers take BCD nibbles [19:16],[15:12],[11:8]; -> IDLE.
REQ-017 Latency: display registers update on the 9th edge after transfer edge; val_ready_o high again on the 10th cycle after transfer.
REQ-018 Display registers hold last value until next LATCH; never partially updated.
REQ-019 Prescaler counts 0..SCAN_DIV-1 and wraps; wrap = scan tick.
REQ-020 Digit index advances units->tens->hundreds->units on each scan tick; an_o reflects index in the same cycle.
REQ-021 seg_o = led7seg encoding of selected digit register, registered with an_o (no glitch between digits).
REQ-022 Leading-zero blanking: hundreds blank if 0; tens blank if hundreds=0 and tens=0; units never blank; blank = seg_o 7'h7F.
REQ-023 Blink counter counts scan ticks 0..BLINK_DIV-1 and toggles blink phase on wrap; runs only while of_i=1, cleared to 0 with phase=on when of_i=0.
REQ-024 of_i=1 and phase=off: seg_o = 7'h7F for all digits; an_o keeps scanning.
REQ-025 Conversion and scanning independent; LATCH mid-scan affects only digits shown from next cycle.

Reset
REQ-026 rst_n low: state=IDLE, val_ready_o=1, busy_o=0, shift register/bit counter=0, display registers=0, prescaler=0, digit index=units, an_o=3'b110, seg_o=pattern for "0", blink counter=0, phase=on.
REQ-027 Reset during CONV/LATCH aborts conversion; display returns to "  0"; no partial value latched.

Structure
REQ-028 Shared package SHALL hold FSM state encodings, digit-index encodings and blank pattern 7'h7F.
REQ-029 One led7seg instance (existing module) SHALL decode the muxed digit; no other sub-modules.

Verification
REQ-030 SCAN_DIV=4: send 255 -> after 9 edges registers 2/5/5; an_o cycles 110,101,011 every 4 cycles; seg_o shows 5,5,2.
REQ-031 Send 7 -> hundreds and tens seg_o=7'h7F, units shows 7; send 100 -> 1,0,0, no blanking.
REQ-032 Send 42 then hold val_valid_i with 99 during CONV -> 42 displayed, 99 dropped; val_ready_o low exactly 9 cycles.
REQ-033 Assert rst_n low at 4th CONV cycle of 200 -> outputs at REQ-026 values; next transfer of 13 displays " 13".
REQ-034 BLINK_DIV=2, SCAN_DIV=4, of_i=1 with 255 shown -> all segments off for 8 cycles, on for 8, repeating; of_i=0 -> steady on next cycle.
REQ-035 Back-to-back: valid held high with 0,1,2 -> each accepted 10 cycles apart, final display "  2".
